afe_spi_sequencer: RTL and testbench

- Command queue and sequencer that sits directly upstream of the AFE SPI shift engine.
- Buffers 16/24-bit SPI command words written by the processor, then issues them back-to-back to the engine. Each issue is a one-cycle strobe plus a 32-bit command word.
- Tracks the engine's busy flag, enforces an inter-transfer gap, and captures each transfer's 24-bit shifted-in readback.

---
 rtl/afe_spi_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_afe_spi_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_spi_sequencer.sv
// Command queue / sequencer in front of the AFE SPI shift engine: buffers command
// words, issues them with an inter-transfer gap, captures readback. Build option AFE_SEQ_READBACK_EN.
module afe_spi_sequencer #(
  parameter int CMD_DEPTH    = 16,
  parameter int RB_DEPTH     = 16,
  parameter int GAP_CYCLES   = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmdWrite,
  input  logic [31:0] cmdData,
  input  logic        start,
  input  logic        abort,
  output logic        spiStrobe,
  output logic [31:0] spiWord,
  input  logic [31:0] spiStatus,
  input  logic        rbRead,
  output logic [23:0] rbData,
  output logic        rbEmpty,
  output logic        cmdFull,
  output logic [4:0]  cmdCount,
  output logic        running,
  output logic [2:0]  errFlags
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

  state_t state, state_nx;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          abort_pend;
  logic          busy;
  logic          cmd_pop, cmd_flush, cmd_push, cmd_ovf;
  logic          capture, to_flag, rb_ovf;
  logic [2:0]    err_q;

  assign busy = spiStatus[31];

  // ---------------- command FIFO ----------------
  logic [31:0]  cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wp, cmd_rp;
  logic [CAW:0]   cmd_cnt;

  assign cmdFull  = (cmd_cnt == (CAW+1)'(CMD_DEPTH));
  assign cmdCount = 5'(cmd_cnt);
  // A flush frees the whole FIFO first, so a write in the same cycle always lands.
  assign cmd_push = cmdWrite && (!cmdFull || cmd_flush);
  assign cmd_ovf  = cmdWrite && cmdFull && !cmd_flush;

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= cmdData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else if (cmd_flush) begin
      cmd_rp  <= cmd_wp;
      cmd_wp  <= cmd_wp + CAW'(cmd_push);
      cmd_cnt <= (CAW+1)'(cmd_push);
    end else begin
      cmd_wp  <= cmd_wp + CAW'(cmd_push);
      cmd_rp  <= cmd_rp + CAW'(cmd_pop);
      cmd_cnt <= cmd_cnt + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
    end
  end

  // ---------------- sequencer FSM ----------------
  always_comb begin
    state_nx  = state;
    cmd_pop   = 1'b0;
    cmd_flush = abort;
    capture   = 1'b0;
    to_flag   = 1'b0;
    case (state)
      S_IDLE: begin
        // Never strobe into a still-busy engine (e.g. one left running across a reset).
        if (start && !abort && cmd_cnt != '0 && !busy) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_pop  = (cmd_cnt != '0);
        state_nx = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy) state_nx = S_WAIT_DONE;
        else if (tcnt >= TW'(BUSY_TIMEOUT - 1)) begin
          to_flag   = 1'b1;
          cmd_flush = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          capture  = 1'b1;
          state_nx = (abort_pend || abort) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (abort) state_nx = S_IDLE;
        else if (gcnt == GW'(GAP_CYCLES - 1)) begin
          if (cmd_cnt == '0) state_nx = S_IDLE;
          else if (!busy)    state_nx = S_ISSUE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // tcnt counts cycles since the strobe, so the timeout flag shows BUSY_TIMEOUT cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      gcnt       <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_ISSUE)          tcnt <= TW'(1);
      else if (state == S_WAIT_BUSY) tcnt <= tcnt + TW'(1);
      if (state == S_WAIT_DONE)      gcnt <= '0;
      else if (state == S_GAP)       gcnt <= gcnt + GW'(1);
      if (state == S_IDLE)           abort_pend <= 1'b0;
      else if (abort)                abort_pend <= 1'b1;
    end
  end

  assign spiStrobe = (state == S_ISSUE);
  assign spiWord   = spiStrobe ? cmd_mem[cmd_rp] : '0;
  assign running   = (state != S_IDLE);

  // ---------------- readback ----------------
`ifdef AFE_SEQ_READBACK_EN
  localparam int RAW = $clog2(RB_DEPTH);
  logic [23:0]    rb_mem [RB_DEPTH];
  logic [RAW-1:0] rb_wp, rb_rp;
  logic [RAW:0]   rb_cnt;
  logic           rb_full, rb_push, rb_pop;

  assign rb_full = (rb_cnt == (RAW+1)'(RB_DEPTH));
  assign rb_push = capture && !rb_full;
  assign rb_ovf  = capture && rb_full;
  assign rb_pop  = rbRead && (rb_cnt != '0);
  assign rbEmpty = (rb_cnt == '0);
  assign rbData  = rbEmpty ? '0 : rb_mem[rb_rp];

  always_ff @(posedge clk) begin
    if (rb_push) rb_mem[rb_wp] <= spiStatus[23:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_wp  <= '0;
      rb_rp  <= '0;
      rb_cnt <= '0;
    end else begin
      rb_wp  <= rb_wp + RAW'(rb_push);
      rb_rp  <= rb_rp + RAW'(rb_pop);
      rb_cnt <= rb_cnt + (RAW+1)'(rb_push) - (RAW+1)'(rb_pop);
    end
  end

  logic unused_ok;
  assign unused_ok = ^spiStatus[30:24];
`else
  logic [23:0] rb_last;
  logic        rb_seen;

  assign rb_ovf  = 1'b0;
  assign rbData  = rb_last;
  assign rbEmpty = !rb_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_last <= '0;
      rb_seen <= 1'b0;
    end else if (capture) begin
      rb_last <= spiStatus[23:0];
      rb_seen <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{spiStatus[30:24], rbRead};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_q | {to_flag, rb_ovf, cmd_ovf};
  end
  assign errFlags = err_q;

endmodule

// File: tb/tb_afe_spi_sequencer.sv
// Directed bench for afe_spi_sequencer with a behavioural SPI engine model
// (busy the cycle after a strobe, 40 cycles long, readback = ~word[23:0]).
module tb_afe_spi_sequencer;
  localparam int GAP = 8;
  localparam int TO  = 15;

  logic        clk = 0, rst_n = 0;
  logic        cmdWrite = 0, start = 0, abort = 0, rbRead = 0;
  logic [31:0] cmdData = '0;
  logic        spiStrobe, rbEmpty, cmdFull, running;
  logic [31:0] spiWord, spiStatus;
  logic [23:0] rbData;
  logic [4:0]  cmdCount;
  logic [2:0]  errFlags;

  afe_spi_sequencer #(.CMD_DEPTH(16), .RB_DEPTH(16), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmdWrite(cmdWrite), .cmdData(cmdData), .start(start),
    .abort(abort), .spiStrobe(spiStrobe), .spiWord(spiWord), .spiStatus(spiStatus),
    .rbRead(rbRead), .rbData(rbData), .rbEmpty(rbEmpty), .cmdFull(cmdFull),
    .cmdCount(cmdCount), .running(running), .errFlags(errFlags));

  always #5 clk = ~clk;

  // engine model: unaffected by the sequencer reset
  int          eng_cnt = 0;
  logic [23:0] eng_sr = '0;
  logic        eng_nobusy = 0;
  assign spiStatus = {eng_cnt != 0, 7'b0, eng_sr};

  always @(posedge clk) begin
    if (spiStrobe && !eng_nobusy) begin
      eng_cnt <= 1;
      eng_sr  <= ~spiWord[23:0];
    end else if (eng_cnt != 0) eng_cnt <= (eng_cnt == 40) ? 0 : eng_cnt + 1;
  end

  int          cyc = 0, strb_n = 0, fall_n = 0, viol = 0;
  int          strb_cyc [64];
  int          fall_cyc [64];
  logic [31:0] strb_word [64];
  logic        prev_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spiStrobe) begin
      if (strb_n < 64) begin
        strb_cyc[strb_n]  <= cyc;
        strb_word[strb_n] <= spiWord;
      end
      strb_n <= strb_n + 1;
      if (spiStatus[31]) viol <= viol + 1;
    end
    if (prev_busy && !spiStatus[31]) begin
      if (fall_n < 64) fall_cyc[fall_n] <= cyc;
      fall_n <= fall_n + 1;
    end
    prev_busy <= spiStatus[31];
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    cmdWrite = 1; cmdData = w;
    @(negedge clk);
    cmdWrite = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic pop_chk(input string tag, input logic [23:0] exp);
    chk({tag, "_empty"}, {31'b0, rbEmpty}, 0);
    chk(tag, {8'b0, rbData}, {8'b0, exp});
    rbRead = 1;
    @(negedge clk);
    rbRead = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (running && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (running) chk("idle_timeout", {31'b0, running}, 0);
  endtask

  logic [31:0] w [3];
  int sb, fb;

  initial begin
    w[0] = 32'h00A5_5A01; w[1] = 32'h8312_3456; w[2] = 32'h0000_FFFF;

    // reset state
    tick(2);
    chk("rst_strobe", {31'b0, spiStrobe}, 0);
    chk("rst_word", spiWord, 0);
    chk("rst_running", {31'b0, running}, 0);
    chk("rst_err", {29'b0, errFlags}, 0);
    chk("rst_count", {27'b0, cmdCount}, 0);
    chk("rst_full", {31'b0, cmdFull}, 0);
    chk("rst_rbempty", {31'b0, rbEmpty}, 1);
    chk("rst_rbdata", {8'b0, rbData}, 0);
    rst_n = 1;
    tick(2);

    // three back-to-back transfers
    sb = strb_n; fb = fall_n;
    for (int i = 0; i < 3; i++) push(w[i]);
    chk("t1_count", {27'b0, cmdCount}, 3);
    pulse_start();
    chk("t1_latency", {31'b0, spiStrobe}, 1);
    chk("t1_word0_now", spiWord, w[0]);
    wait_idle(600);
    chk("t1_nstrobe", strb_n - sb, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_word%0d", i), strb_word[sb+i], w[i]);
    chk("t1_gap1", strb_cyc[sb+1] - fall_cyc[fb], GAP + 1);
    chk("t1_gap2", strb_cyc[sb+2] - fall_cyc[fb+1], GAP + 1);
    chk("t1_run_drop", cyc - fall_cyc[fall_n-1], GAP + 1);
`ifdef AFE_SEQ_READBACK_EN
    pop_chk("t1_rb0", 24'h5AA5FE);
    pop_chk("t1_rb1", 24'hEDCBA9);
    pop_chk("t1_rb2", 24'hFF0000);
    chk("t1_rb_drained", {31'b0, rbEmpty}, 1);
`else
    chk("t1_rblast", {8'b0, rbData}, 32'h00FF_0000);
    chk("t1_rbempty", {31'b0, rbEmpty}, 0);
`endif

    // command FIFO overflow, abort+write, abort+start
    for (int i = 0; i < 16; i++) push(32'h0100_0000 + i);
    chk("t2_full", {31'b0, cmdFull}, 1);
    chk("t2_count16", {27'b0, cmdCount}, 16);
    chk("t2_err_pre", {29'b0, errFlags}, 0);
    push(32'hDEAD_BEEF);
    chk("t2_count_hold", {27'b0, cmdCount}, 16);
    chk("t2_err_ovf", {29'b0, errFlags}, 3'b001);
    abort = 1; cmdWrite = 1; cmdData = 32'h0200_0042;
    @(negedge clk);
    abort = 0; cmdWrite = 0;
    chk("t2_abort_wr_count", {27'b0, cmdCount}, 1);
    chk("t2_abort_wr_err", {29'b0, errFlags}, 3'b001);
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    chk("t2_abort_start_run", {31'b0, running}, 0);
    chk("t2_abort_start_cnt", {27'b0, cmdCount}, 0);
    tick(2);

    // busy timeout
    eng_nobusy = 1;
    push(32'h0300_0001); push(32'h0300_0002);
    pulse_start();
    chk("t3_strobe", {31'b0, spiStrobe}, 1);
    tick(TO - 1);
    chk("t3_err_early", {31'b0, errFlags[2]}, 0);
    tick(1);
    chk("t3_err_to", {29'b0, errFlags}, 3'b101);
    chk("t3_count", {27'b0, cmdCount}, 0);
    chk("t3_running", {31'b0, running}, 0);
    eng_nobusy = 0;
    tick(2);

    // abort during the first transfer's busy phase
    sb = strb_n;
    for (int i = 0; i < 4; i++) push(32'h0100_0011 + i);
    pulse_start();
    tick(5);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t4_count", {27'b0, cmdCount}, 0);
    chk("t4_still_run", {31'b0, running}, 1);
    wait_idle(100);
    chk("t4_nstrobe", strb_n - sb, 1);
    chk("t4_run_drop", cyc - fall_cyc[fall_n-1], 1);
`ifdef AFE_SEQ_READBACK_EN
    pop_chk("t4_rb", 24'hFFFFEE);
    chk("t4_rb_one", {31'b0, rbEmpty}, 1);
`else
    chk("t4_rblast", {8'b0, rbData}, 32'h00FF_FFEE);
`endif

    // reset mid-transfer with two commands queued
    sb = strb_n;
    push(32'h0400_0001); push(32'h0400_0002); push(32'h0400_0003);
    pulse_start();
    tick(10);
    chk("t5_count_pre", {27'b0, cmdCount}, 2);
    rst_n = 0;
    #1;
    chk("t5_strobe", {31'b0, spiStrobe}, 0);
    chk("t5_count", {27'b0, cmdCount}, 0);
    chk("t5_rbempty", {31'b0, rbEmpty}, 1);
    chk("t5_running", {31'b0, running}, 0);
    chk("t5_err", {29'b0, errFlags}, 0);
    tick(2);
    rst_n = 1;
    tick(50);
    chk("t5_no_strobe", strb_n - sb, 1);
    push(32'h0400_0077);
    pulse_start();
    chk("t5_restart", {31'b0, spiStrobe}, 1);
    chk("t5_restart_word", spiWord, 32'h0400_0077);
    wait_idle(100);
`ifdef AFE_SEQ_READBACK_EN
    pop_chk("t5_rb", 24'hFFFF88);
`endif

    // readback capture: 0x123456 then 0xABCDEF
    push(32'h00ED_CBA9); push(32'h8054_3210);
    pulse_start();
    wait_idle(300);
`ifdef AFE_SEQ_READBACK_EN
    pop_chk("t6_rb0", 24'h123456);
    pop_chk("t6_rb1", 24'hABCDEF);
    chk("t6_empty", {31'b0, rbEmpty}, 1);
`else
    chk("t6_rblast", {8'b0, rbData}, 32'h00AB_CDEF);
    chk("t6_rbempty", {31'b0, rbEmpty}, 0);
    rbRead = 1;
    @(negedge clk);
    rbRead = 0;
    chk("t6_rbread_ign", {8'b0, rbData}, 32'h00AB_CDEF);
    chk("t6_rbempty_ign", {31'b0, rbEmpty}, 0);
`endif
    chk("t6_err1", {31'b0, errFlags[1]}, 0);
    chk("strobe_while_busy", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end
endmodule
